// File: rtl/lsdalu_sequencer.sv
// Accumulator controller for the combinational lsdalu.
// Takes commands over a valid/ready handshake, drives the ALU ports and writes
// results back into the accumulator and flag registers. MUL is a shift/add
// macro that reuses the same ALU for 2*WIDTH cycles.
module lsdalu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opr,
    input  logic [WIDTH-1:0] alu_r,
    input  logic [3:0]       alu_flags
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_MUL_SHIFT = 3'd2,
        S_MUL_ADD   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [2:0]       op_q, op_d;

    logic accept;
    logic is_mul;
    logic last_bit;
    logic opnd_bit;

    assign accept   = (state_q == S_IDLE) && cmd_valid;
    assign is_mul   = (cmd_op == 4'b1000);
    assign last_bit = (bit_idx_q == '0);
    assign opnd_bit = opnd_q[bit_idx_q];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_op[3])  state_d = S_EXEC;
                    else if (is_mul) state_d = S_MUL_SHIFT;
                    else             state_d = S_DONE;
                end
            end
            S_EXEC:      state_d = S_DONE;
            S_MUL_SHIFT: state_d = S_MUL_ADD;
            S_MUL_ADD:   state_d = last_bit ? S_DONE : S_MUL_SHIFT;
            S_DONE:      if (rsp_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs: ALU drive and handshake flags decoded from the current state
    always_comb begin
        alu_a     = acc_q;
        alu_b     = '0;
        alu_opr   = 3'b000;
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_EXEC: begin
                alu_b   = opnd_q;
                alu_opr = op_q;
            end
            S_MUL_SHIFT: begin
                alu_a   = prod_q;
                alu_opr = 3'b101;
            end
            S_MUL_ADD: begin
                alu_a   = prod_q;
                alu_b   = mcand_q;
                alu_opr = 3'b010;
            end
            default: ;
        endcase
    end

    // Datapath next-state: accept latching, EXEC write-back, MUL iteration
    always_comb begin
        acc_d     = acc_q;
        flags_d   = flags_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        bit_idx_d = bit_idx_q;
        op_d      = op_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opnd_d = cmd_data;
                    op_d   = cmd_op[2:0];
                    if (is_mul) begin
                        mcand_d   = acc_q;
                        prod_d    = '0;
                        bit_idx_d = IDX_TOP;
                    end else if (cmd_op == 4'b1001) begin
                        acc_d   = '0;
                        flags_d = '0;
                    end
                end
            end
            S_EXEC: begin
                acc_d   = alu_r;
                flags_d = alu_flags;
            end
            S_MUL_SHIFT: begin
                prod_d = alu_r;
            end
            S_MUL_ADD: begin
                // Multiplier bits are consumed MSB first; add only where set.
                if (opnd_bit) prod_d = alu_r;
                if (last_bit) begin
                    acc_d   = opnd_q[0] ? alu_r : prod_q;
                    flags_d = alu_flags;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any multiply in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            flags_q   <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            bit_idx_q <= IDX_TOP;
            op_q      <= '0;
        end else begin
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            bit_idx_q <= bit_idx_d;
            op_q      <= op_d;
        end
    end

    assign acc   = acc_q;
    assign flags = flags_q;

endmodule
